// File: rtl/dbus_pkg.sv
// Shared constants and helpers for the MiniMIPS32 data-side bus bridge.
package dbus_pkg;

  localparam int unsigned RAM_AW        = 16;
  localparam int unsigned LED_W         = 16;
  localparam int unsigned SW_W          = 8;
  localparam int unsigned INT_W         = 6;
  localparam int unsigned IRQ_TIMER_BIT = 5;

  localparam logic [12:0] PERIPH_TAG = 13'h1FAF;

  localparam logic [15:0] OFF_LED     = 16'hF000;
  localparam logic [15:0] OFF_SW      = 16'hF010;
  localparam logic [15:0] OFF_TIMER   = 16'hE000;
  localparam logic [15:0] OFF_COMPARE = 16'hE004;
  localparam logic [15:0] OFF_STATUS  = 16'hE008;

  // Replace only the byte lanes whose enable is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) r[8*k +: 8] = wdata[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dbus_bridge_if.sv
// Core data-port bus: request from the core, one-cycle-latency read data back.
interface dbus_bridge_if;
  logic [31:0] daddr;
  logic        dce;
  logic [3:0]  we;
  logic [31:0] din;
  logic [31:0] dm;

  modport master (output daddr, dce, we, din, input dm);
  modport slave  (input daddr, dce, we, din, output dm);
endinterface

// File: rtl/dbus_timer.sv
// Free-running timer with compare match and sticky IRQ pending flag.
module dbus_timer
  import dbus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_timer,
  input  logic        wr_compare,
  input  logic        wr_status,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] timer,
  output logic [31:0] compare,
  output logic        irq
);

  logic irq_set_c;
  logic irq_clr_c;

  assign irq_set_c = (timer == compare);
  assign irq_clr_c = wr_compare | (wr_status & be[0] & wdata[0]);

  // A set and a clear in the same cycle leave the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer   <= '0;
      compare <= '0;
      irq     <= 1'b0;
    end else begin
      timer <= wr_timer ? byte_merge(timer, wdata, be) : timer + 32'd1;
      if (wr_compare) compare <= byte_merge(compare, wdata, be);
      irq <= irq_set_c | (irq & ~irq_clr_c);
    end
  end

endmodule

// File: rtl/dbus_bridge.sv
// Data-side bridge: splits core accesses between external SRAM and on-chip
// peripheral registers, returning read data with the SRAM's one-cycle latency.
module dbus_bridge
  import dbus_pkg::*;
(
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  dbus_bridge_if.slave      bus,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic [SW_W-1:0]   sw,
  output logic [LED_W-1:0]  led,
  output logic [INT_W-1:0]  int_o
);

  logic              periph_c;
  logic              pwr_c;
  logic [15:0]       offs_c;
  logic [31:0]       rdata_c;
  logic [SW_W-1:0]   sw_meta;
  logic [SW_W-1:0]   sw_sync;
  logic              sel_periph;
  logic [31:0]       periph_rdata;
  logic [31:0]       timer;
  logic [31:0]       compare;
  logic              irq;
  logic              unused_ok;

  assign periph_c  = (bus.daddr[28:16] == PERIPH_TAG);
  assign offs_c    = bus.daddr[15:0];
  assign pwr_c     = bus.dce & periph_c & (|bus.we);
  assign unused_ok = &{1'b0, bus.daddr[31:29]};

  assign ram_en    = bus.dce & ~periph_c;
  assign ram_we    = ram_en ? bus.we : 4'b0000;
  assign ram_addr  = bus.daddr[RAM_AW+1:2];
  assign ram_wdata = bus.din;

  dbus_timer u_timer (
    .clk        (cpu_clk_50M),
    .rst_n      (cpu_rst_n),
    .wr_timer   (pwr_c && offs_c == OFF_TIMER),
    .wr_compare (pwr_c && offs_c == OFF_COMPARE),
    .wr_status  (pwr_c && offs_c == OFF_STATUS),
    .be         (bus.we),
    .wdata      (bus.din),
    .timer      (timer),
    .compare    (compare),
    .irq        (irq)
  );

  // Register read mux; unmapped offsets read as zero.
  always_comb begin
    rdata_c = '0;
    unique case (offs_c)
      OFF_LED:     rdata_c = 32'(led);
      OFF_SW:      rdata_c = 32'(sw_sync);
      OFF_TIMER:   rdata_c = timer;
      OFF_COMPARE: rdata_c = compare;
      OFF_STATUS:  rdata_c = {31'd0, irq};
      default:     rdata_c = '0;
    endcase
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      sw_meta      <= '0;
      sw_sync      <= '0;
      led          <= '0;
      sel_periph   <= 1'b1;
      periph_rdata <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      if (pwr_c && offs_c == OFF_LED) led <= LED_W'(byte_merge(32'(led), bus.din, bus.we));
      if (bus.dce) begin
        sel_periph   <= periph_c;
        periph_rdata <= rdata_c;
      end
    end
  end

  assign bus.dm = sel_periph ? periph_rdata : ram_rdata;

  always_comb begin
    int_o                = '0;
    int_o[IRQ_TIMER_BIT] = irq;
  end

endmodule

// File: tb/tb_dbus_bridge.sv
// Directed vector bench for dbus_bridge with a read-first SRAM model.
module tb_dbus_bridge;
  import dbus_pkg::*;

  localparam logic [31:0] A_LED  = 32'hBFAF_F000;
  localparam logic [31:0] A_SW   = 32'hBFAF_F010;
  localparam logic [31:0] A_TMR  = 32'hBFAF_E000;
  localparam logic [31:0] A_CMP  = 32'hBFAF_E004;
  localparam logic [31:0] A_STAT = 32'hBFAF_E008;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = '0;
  logic [SW_W-1:0]   sw;
  logic [LED_W-1:0]  led;
  logic [INT_W-1:0]  int_o;
  logic [31:0]       mem [0:255] = '{default: '0};

  int n_tests = 0;
  int n_fail  = 0;

  dbus_bridge_if bus ();

  dbus_bridge dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .bus         (bus),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .sw          (sw),
    .led         (led),
    .int_o       (int_o)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM model, old data returned on a write.
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr[7:0]];
      for (int k = 0; k < 4; k++)
        if (ram_we[k]) mem[ram_addr[7:0]][8*k +: 8] <= ram_wdata[8*k +: 8];
    end
  end

  typedef struct {
    logic [31:0] daddr;
    logic        dce;
    logic [3:0]  we;
    logic [31:0] din;
    logic        e_ram_en;
    logic [3:0]  e_ram_we;
    logic [15:0] e_ram_addr;
    logic        chk_dm;
    logic [31:0] e_dm;
    logic [15:0] e_led;
  } vec_t;

  vec_t vec [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    bus.daddr = a; bus.dce = 1'b1; bus.we = w; bus.din = d;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.dce = 1'b0; bus.we = 4'h0;
    @(posedge clk); #1;
  endtask

  initial begin
    vec[0]  = '{32'h8000_0010, 1'b1, 4'hF, 32'h1234_5678, 1'b1, 4'hF, 16'h0004, 1'b0, 32'h0,         16'h0000};
    vec[1]  = '{32'h8000_0010, 1'b1, 4'h0, 32'h0,         1'b1, 4'h0, 16'h0004, 1'b1, 32'h1234_5678, 16'h0000};
    vec[2]  = '{A_LED,         1'b1, 4'hF, 32'h0000_A5A5, 1'b0, 4'h0, 16'hFC00, 1'b1, 32'h0,         16'hA5A5};
    vec[3]  = '{A_LED,         1'b1, 4'h0, 32'h0,         1'b0, 4'h0, 16'hFC00, 1'b1, 32'h0000_A5A5, 16'hA5A5};
    vec[4]  = '{A_LED,         1'b1, 4'h1, 32'hFFFF_00FF, 1'b0, 4'h0, 16'hFC00, 1'b1, 32'h0000_A5A5, 16'hA5FF};
    vec[5]  = '{A_LED,         1'b1, 4'h0, 32'h0,         1'b0, 4'h0, 16'hFC00, 1'b1, 32'h0000_A5FF, 16'hA5FF};
    vec[6]  = '{A_LED,         1'b1, 4'hC, 32'h1234_0000, 1'b0, 4'h0, 16'hFC00, 1'b1, 32'h0000_A5FF, 16'hA5FF};
    vec[7]  = '{32'hBFAF_1234, 1'b1, 4'h0, 32'h0,         1'b0, 4'h0, 16'hC48D, 1'b1, 32'h0,         16'hA5FF};
    vec[8]  = '{32'hBFAF_1234, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0, 4'h0, 16'hC48D, 1'b1, 32'h0,         16'hA5FF};
    vec[9]  = '{A_LED,         1'b1, 4'h0, 32'h0,         1'b0, 4'h0, 16'hFC00, 1'b1, 32'h0000_A5FF, 16'hA5FF};
    vec[10] = '{A_LED,         1'b0, 4'hF, 32'hFFFF_FFFF, 1'b0, 4'h0, 16'hFC00, 1'b1, 32'h0000_A5FF, 16'hA5FF};
    vec[11] = '{32'h0000_0010, 1'b1, 4'h0, 32'h0,         1'b1, 4'h0, 16'h0004, 1'b1, 32'h1234_5678, 16'hA5FF};
    vec[12] = '{32'h9FAF_F000, 1'b1, 4'h0, 32'h0,         1'b0, 4'h0, 16'hFC00, 1'b1, 32'h0000_A5FF, 16'hA5FF};
    vec[13] = '{32'hBFAE_F000, 1'b1, 4'h0, 32'h0,         1'b1, 4'h0, 16'hBC00, 1'b0, 32'h0,         16'hA5FF};
    vec[14] = '{32'h8000_0010, 1'b1, 4'h6, 32'hAABB_CCDD, 1'b1, 4'h6, 16'h0004, 1'b1, 32'h1234_5678, 16'hA5FF};
    vec[15] = '{32'h8000_0010, 1'b1, 4'h0, 32'h0,         1'b1, 4'h0, 16'h0004, 1'b1, 32'h12BB_CC78, 16'hA5FF};

    rst_n = 1'b0; sw = '0;
    bus.daddr = '0; bus.dce = 1'b0; bus.we = 4'h0; bus.din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dm", bus.dm, 32'h0);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_int", 32'(int_o), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      bus.daddr = vec[i].daddr; bus.dce = vec[i].dce; bus.we = vec[i].we; bus.din = vec[i].din;
      #1;
      chk($sformatf("v%0d_ram_en", i), 32'(ram_en), 32'(vec[i].e_ram_en));
      chk($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vec[i].e_ram_we));
      chk($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(vec[i].e_ram_addr));
      chk($sformatf("v%0d_ram_wdata", i), ram_wdata, vec[i].din);
      @(posedge clk); #1;
      if (vec[i].chk_dm) chk($sformatf("v%0d_dm", i), bus.dm, vec[i].e_dm);
      chk($sformatf("v%0d_led", i), 32'(led), 32'(vec[i].e_led));
    end

    // Compare match raises the IRQ at the edge after TIMER reads 0x20.
    access(A_CMP, 4'hF, 32'h20);
    chk("cmp_wr_clr", 32'(int_o), 32'h0);
    access(A_TMR, 4'hF, 32'h10);
    for (int k = 0; k < 18; k++) begin
      access(A_TMR, 4'h0, 32'h0);
      chk($sformatf("tmr_rd%0d", k), bus.dm, 32'h10 + 32'(k));
      chk($sformatf("tmr_int%0d", k), 32'(int_o), (k >= 16) ? 32'h20 : 32'h0);
    end
    access(A_STAT, 4'hF, 32'hFFFF_FFFE);
    chk("stat_w0_keep", 32'(int_o), 32'h20);
    access(A_STAT, 4'h1, 32'h1);
    chk("stat_w1_clr", 32'(int_o), 32'h0);

    // STATUS clear in the match cycle: set wins.
    access(A_TMR, 4'hF, 32'h1E);
    idle();
    idle();
    chk("pre_match_int", 32'(int_o), 32'h0);
    access(A_STAT, 4'h1, 32'h1);
    chk("set_wins", 32'(int_o), 32'h20);
    access(A_CMP, 4'hF, 32'h20);
    chk("cmp_wr_clr2", 32'(int_o), 32'h0);

    // Wrap-around.
    access(A_TMR, 4'hF, 32'hFFFF_FFFE);
    access(A_TMR, 4'h0, 32'h0);
    chk("wrap0", bus.dm, 32'hFFFF_FFFE);
    access(A_TMR, 4'h0, 32'h0);
    chk("wrap1", bus.dm, 32'hFFFF_FFFF);
    access(A_TMR, 4'h0, 32'h0);
    chk("wrap2", bus.dm, 32'h0000_0000);

    // Switch synchronizer.
    sw = 8'h3C;
    access(A_SW, 4'h0, 32'h0);
    chk("sw_rd0", bus.dm, 32'h0);
    access(A_SW, 4'h0, 32'h0);
    chk("sw_rd1", bus.dm, 32'h0);
    access(A_SW, 4'h0, 32'h0);
    chk("sw_rd2", bus.dm, 32'h0000_003C);

    // Reset in the cycle after a peripheral read.
    access(A_CMP, 4'hF, 32'h101);
    access(A_TMR, 4'hF, 32'h100);
    idle();
    access(A_LED, 4'h0, 32'h0);
    chk("pre_rst_dm", bus.dm, 32'h0000_A5FF);
    chk("pre_rst_int", 32'(int_o), 32'h20);
    rst_n = 1'b0;
    access(A_LED, 4'h0, 32'h0);
    chk("mid_rst_dm", bus.dm, 32'h0);
    chk("mid_rst_led", 32'(led), 32'h0);
    chk("mid_rst_int", 32'(int_o), 32'h0);
    rst_n = 1'b1;
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
